toggle_descrambler: RTL

Receive-side counterpart of the team's alternating-toggle line encoder, which sends each data bit XORed with a free-running 1-bit toggle that flips every clock. This block takes that serial stream, finds the toggle phase by hunting for a framing sync word under both phase hypotheses, removes the toggle, and deserializes the payload into WIDTH-bit words. It sits directly after the serial input register on the receive path and feeds word-wide consumers.

---
 rtl/toggle_rx_pkg.sv | 7 +
 rtl/toggle_sync_detect.sv | 33 +++
 rtl/toggle_descrambler.sv | 112 +++++++++++
 3 files changed

// File: rtl/toggle_rx_pkg.sv
// toggle_rx_pkg: shared receive-state type and constants for the toggle descrambler
package toggle_rx_pkg;
    typedef enum logic {HUNT, LOCKED} rx_state_t;
    localparam logic [7:0] DEFAULT_SYNC = 8'h47;
    localparam int MISS_TOTAL_W = 16;
    localparam int LOCK_CNT_W = 8;
endpackage

// File: rtl/toggle_sync_detect.sv
// toggle_sync_detect: local toggle generator and dual-polarity sync hunter
module toggle_sync_detect
    import toggle_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DEFAULT_SYNC)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic shift,
    input  logic clear,
    output logic t,
    output logic match_pos,
    output logic match_neg
);
    logic [WIDTH-1:0] sr, sr_nxt;

    // Compare against the value sr takes on this edge so lock lands one edge after the last sync bit
    assign sr_nxt = {sr[WIDTH-2:0], din ^ t};
    assign match_pos = shift && sr_nxt == SYNC_WORD;
    assign match_neg = shift && sr_nxt == ~SYNC_WORD;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t <= 1'b0;
            sr <= '0;
        end else begin
            t <= ~t;
            sr <= clear ? '0 : shift ? sr_nxt : sr;
        end
    end
endmodule

// File: rtl/toggle_descrambler.sv
// toggle_descrambler: phase-hunting toggle remover and word deserializer.
// Optional stats outputs enabled by TOGGLE_DESCRAMBLER_STATS_EN.
module toggle_descrambler
    import toggle_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DEFAULT_SYNC),
    parameter int FRAME_WORDS = 4,
    parameter int MISS_LIMIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic [WIDTH-1:0] dout,
    output logic dout_valid,
    output logic locked
`ifdef TOGGLE_DESCRAMBLER_STATS_EN
    ,
    output logic [MISS_TOTAL_W-1:0] sync_miss_total,
    output logic [LOCK_CNT_W-1:0] lock_count
`endif
);
    localparam int BW = $clog2(WIDTH);
    localparam int FWW = $clog2(FRAME_WORDS + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [FWW-1:0] LAST_SLOT = FWW'(FRAME_WORDS);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_LIMIT - 1);

    rx_state_t state, state_nxt;
    logic t, p, b, match_pos, match_neg, lock_ev, word_done, miss, unlock;
    logic [WIDTH-1:0] wsr, word;
    logic [BW-1:0] bc;
    logic [FWW-1:0] wc;
    logic [MW-1:0] mc;

    toggle_sync_detect #(.WIDTH(WIDTH), .SYNC_WORD(SYNC_WORD)) u_sync (
        .clk(clk),
        .rst_n(rst_n),
        .din(din),
        .shift(state == HUNT),
        .clear(unlock),
        .t(t),
        .match_pos(match_pos),
        .match_neg(match_neg)
    );

    assign locked = state == LOCKED;

    always_comb begin
        b = din ^ t ^ p;
        word = {wsr[WIDTH-2:0], b};
        lock_ev = state == HUNT && (match_pos || match_neg);
        word_done = state == LOCKED && bc == LAST_BIT;
        miss = word_done && wc == '0 && word != SYNC_WORD;
        unlock = miss && mc == MISS_LAST;
        state_nxt = lock_ev ? LOCKED : unlock ? HUNT : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= HUNT;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p <= 1'b0;
            wsr <= '0;
            bc <= '0;
            wc <= '0;
            mc <= '0;
            dout <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (lock_ev) begin
                // The sync word just matched fills slot 0, so the next word is data slot 1
                p <= match_neg;
                bc <= '0;
                wc <= FWW'(1);
                mc <= '0;
            end else if (state == LOCKED) begin
                wsr <= word;
                bc <= word_done ? '0 : bc + 1'b1;
                if (word_done) begin
                    wc <= wc == LAST_SLOT ? '0 : wc + 1'b1;
                    if (wc != '0) begin
                        dout <= word;
                        dout_valid <= 1'b1;
                    end else
                        mc <= miss ? mc + 1'b1 : '0;
                end
            end
        end
    end

`ifdef TOGGLE_DESCRAMBLER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_miss_total <= '0;
            lock_count <= '0;
        end else begin
            if (miss && sync_miss_total != '1)
                sync_miss_total <= sync_miss_total + 1'b1;
            if (lock_ev && lock_count != '1)
                lock_count <= lock_count + 1'b1;
        end
    end
`endif
endmodule
